// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - first-word-fall-through FIFO that drops and flags words arriving while full
module stream_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  ivalid,
    input  logic [DATA_WIDTH-1:0] idata,
    output logic                  iready,
    output logic                  ovalid,
    output logic [DATA_WIDTH-1:0] odata,
    input  logic                  oready,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow
);

    localparam int                DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic                  r_overflow;

    logic [ADDR_WIDTH:0]   w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_drop;

    // Status decodes only registered pointers, so no input reaches an output combinationally
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_count == DEPTH_CNT);
    assign w_empty = (w_count == '0);

    assign w_push  = ivalid & ~w_full;
    assign w_pop   = ~w_empty & oready;
    assign w_drop  = ivalid & w_full;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage is deliberately left unreset; stale words are never visible past the pointers
    always_ff @(posedge sys_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= idata;
        end
    end

    assign odata    = r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
    assign ovalid   = ~w_empty;
    assign iready   = ~w_full;
    assign count    = w_count;
    assign full     = w_full;
    assign empty    = w_empty;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_stream_fifo.sv
// tb/tb_stream_fifo.sv - randomized self-checking bench for stream_fifo against a queue model
module tb_stream_fifo;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          sys_clk;
    logic          sys_rst;
    logic          ivalid;
    logic [DW-1:0] idata;
    logic          iready;
    logic          ovalid;
    logic [DW-1:0] odata;
    logic          oready;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          overflow;

    stream_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .ivalid   (ivalid),
        .idata    (idata),
        .iready   (iready),
        .ovalid   (ovalid),
        .odata    (odata),
        .oready   (oready),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic [DW-1:0] q[$];
    bit            m_ovf;
    int            n_total;
    int            n_pass;
    int            n_pushed;

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_state();
        chk("count",    int'(count),    q.size());
        chk("empty",    int'(empty),    int'(q.size() == 0));
        chk("full",     int'(full),     int'(q.size() == DEPTH));
        chk("iready",   int'(iready),   int'(q.size() != DEPTH));
        chk("ovalid",   int'(ovalid),   int'(q.size() != 0));
        chk("overflow", int'(overflow), int'(m_ovf));
        if (q.size() != 0) chk("odata", int'(odata), int'(q[0]));
    endtask

    // Model rules: full is judged before the edge; pop needs a nonempty queue
    task automatic step(input bit v, input logic [DW-1:0] d, input bit r);
        bit            was_full;
        logic [DW-1:0] popped;
        ivalid = v;
        idata  = d;
        oready = r;
        @(posedge sys_clk);
        was_full = (q.size() == DEPTH);
        if (r && q.size() != 0) popped = q.pop_front();
        if (v && !was_full) begin
            q.push_back(d);
            n_pushed++;
        end
        if (v && was_full) m_ovf = 1'b1;
        @(negedge sys_clk);
        check_state();
    endtask

    task automatic drain_all();
        for (int i = 0; i < 4 * DEPTH && q.size() != 0; i++) step(1'b0, '0, 1'b1);
        chk("drained_empty", int'(empty), 1);
    endtask

    initial begin
        n_total  = 0;
        n_pass   = 0;
        n_pushed = 0;
        m_ovf    = 1'b0;
        sys_rst  = 1'b1;
        ivalid   = 1'b0;
        idata    = '0;
        oready   = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("rst_count",  int'(count),    0);
        chk("rst_empty",  int'(empty),    1);
        chk("rst_full",   int'(full),     0);
        chk("rst_iready", int'(iready),   1);
        chk("rst_ovalid", int'(ovalid),   0);
        chk("rst_ovf",    int'(overflow), 0);
        sys_rst = 1'b0;

        // Free-running stream with consumer always ready
        for (int i = 0; i < 24; i++) begin
            step(1'b1, DW'(i), 1'b1);
            chk("stream_cnt_le1", int'(count <= 1), 1);
        end
        drain_all();

        // Fill to depth, then drain in order
        for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(i), 1'b0);
        chk("fill_full",   int'(full),   1);
        chk("fill_iready", int'(iready), 0);
        chk("fill_count",  int'(count),  DEPTH);
        chk("fill_head",   int'(odata),  0);
        for (int i = 0; i < DEPTH; i++) begin
            chk("fill_drain", int'(odata), i);
            step(1'b0, '0, 1'b1);
        end
        chk("fill_empty", int'(empty), 1);

        // Overflow: two extra words are dropped
        for (int i = 0; i < DEPTH + 2; i++) step(1'b1, DW'(i), 1'b0);
        chk("ovf_flag",  int'(overflow), 1);
        chk("ovf_count", int'(count),    DEPTH);
        step(1'b1, 8'hAA, 1'b1);
        chk("fullpp_count", int'(count),    DEPTH - 1);
        chk("fullpp_ovf",   int'(overflow), 1);
        chk("fullpp_head",  int'(odata),    1);
        for (int i = 1; i < DEPTH; i++) begin
            chk("ovf_drain", int'(odata), i);
            step(1'b0, '0, 1'b1);
        end
        chk("ovf_sticky", int'(overflow), 1);

        // Asynchronous reset in the middle of a cycle
        for (int i = 0; i < 7; i++) step(1'b1, DW'(8'h30 + i), 1'b0);
        #2 sys_rst = 1'b1;
        #1;
        q.delete();
        m_ovf = 1'b0;
        chk("arst_count",  int'(count),    0);
        chk("arst_ovalid", int'(ovalid),   0);
        chk("arst_ovf",    int'(overflow), 0);
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        step(1'b1, 8'h55, 1'b0);
        chk("arst_first", int'(odata), 8'h55);
        drain_all();

        // Wrap-around with toggling consumer, occupancy capped at 10
        n_pushed = 0;
        for (int c = 0; c < 400 && n_pushed < 40; c++) begin
            step(q.size() < 10, DW'(n_pushed + 8'h80), c[0]);
            chk("wrap_occ", int'(count <= 10), 1);
        end
        chk("wrap_pushed", n_pushed, 40);
        drain_all();
        chk("wrap_noovf", int'(overflow), 0);

        // Randomized traffic, including overflow periods
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 70), DW'($urandom), ($urandom_range(0, 99) < (i < 300 ? 40 : 75)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got %0d expected %0d", n_total, 0);
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1);
    end

endmodule
